load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/load_store_unit_load_align.sv | 34 +++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM encoding, RV32I size codes and exception causes.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_BUS      = 2'd2;
    localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

    // size is funct3[1:0]: 00 byte, 01 half, anything else a word
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] lo);
        logic m;
        unique case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = lo[0];
            default: m = (lo != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data lane select and sign/zero extension.
// Unknown load encodings fall through as full words.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[7:0];
        unique case (addr_lo)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            2'd3: b = rdata[31:24];
        endcase
        h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data = rdata;
        unique case (funct3)
            F3_LB:   data = {{24{b[7]}}, b};
            F3_LH:   data = {{16{h[15]}}, h};
            F3_LBU:  data = {24'd0, b};
            F3_LHU:  data = {16'd0, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding bus access per request,
// with alignment checks, response timeout and a one-cycle writeback.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_we,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rsp_err,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic        busy
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [15:0] cnt_q;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] data_q, data_d;
    logic [31:0] ld_data;
    logic        accept, mis, done;

    load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (f3_q),
        .data    (ld_data)
    );

    assign accept = req_valid && req_ready;
    assign mis    = misaligned(req_funct3[1:0], req_addr[1:0]);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: if (accept) begin
                data_d  = '0;
                cause_d = mis ? EXC_MISALIGN : EXC_NONE;
                state_d = mis ? S_DONE : S_REQ;
            end
            S_REQ: if (mem_req_ready) state_d = S_WAIT;
            // a response in the final counted cycle beats the timeout
            S_WAIT: if (mem_rsp_valid) begin
                state_d = S_DONE;
                cause_d = mem_rsp_err ? EXC_BUS : EXC_NONE;
                data_d  = (mem_rsp_err || store_q) ? '0 : ld_data;
            end else if (cnt_q == CNT_LAST) begin
                state_d = S_DONE;
                cause_d = EXC_TIMEOUT;
                data_d  = '0;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
            f3_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            cause_q <= EXC_NONE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            data_q  <= data_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                store_q <= req_is_store;
                f3_q    <= req_funct3;
                rd_q    <= req_rd;
            end
            if (state_q == S_REQ)
                cnt_q <= '0;
            else if (state_q == S_WAIT)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb begin
        mem_wstrb = 4'b0000;
        mem_wdata = wdata_q;
        unique case (f3_q[1:0])
            2'b00: begin
                mem_wstrb = 4'b0001 << addr_q[1:0];
                mem_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                mem_wstrb = 4'b0011 << addr_q[1:0];
                mem_wdata = {2{wdata_q[15:0]}};
            end
            default: mem_wstrb = 4'b1111;
        endcase
        if (!store_q) mem_wstrb = 4'b0000;
    end

    assign done          = (state_q == S_DONE);
    assign req_ready     = (state_q == S_IDLE);
    assign busy          = !req_ready;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_we        = store_q;
    assign wb_valid      = done;
    assign wb_rd         = done ? rd_q : 5'd0;
    assign wb_data       = done ? data_q : 32'd0;
    assign exc_cause     = done ? cause_q : EXC_NONE;
    assign exc_valid     = done && (cause_q != EXC_NONE);
    assign wb_we         = done && !store_q &&
                           (cause_q == EXC_NONE) && (rd_q != 5'd0);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a behavioural model.
// Directed corner cases followed by randomized transactions.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_we;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        mem_rsp_err;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic        busy;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_is_store  (req_is_store),
        .req_funct3    (req_funct3),
        .req_rd        (req_rd),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_we        (mem_we),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .mem_rsp_err   (mem_rsp_err),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .exc_valid     (exc_valid),
        .exc_cause     (exc_cause),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned nbytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3,
                                             input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (addr % 4));
        if (nbytes(f3) == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 128) v = v - 256;
        end else if (nbytes(f3) == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic done_check(input logic [4:0] rd, input logic [31:0] data,
                              input logic [1:0] cause, input bit st);
        check("wb_valid", wb_valid, 1);
        check("wb_rd", wb_rd, rd);
        check("wb_data", wb_data, data);
        check("exc_cause", exc_cause, cause);
        check("exc_valid", exc_valid, cause != 0);
        check("wb_we", wb_we, !st && cause == 0 && rd != 0);
    endtask

    task automatic txn(input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [31:0] rdata,
                       input int rdy_dly, input int rsp_dly,
                       input bit err, input bit tmo);
        int unsigned n;
        logic [31:0] strb;
        n = nbytes(f3);
        @(negedge clk);
        check("req_ready", req_ready, 1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        if (addr % n != 0) begin
            check("mis_no_req", mem_req_valid, 0);
            done_check(rd, 0, 1, st);
        end else begin
            strb = st ? (((1 << n) - 1) << (addr % 4)) : 0;
            check("req_valid", mem_req_valid, 1);
            check("mem_addr", mem_addr, addr & ~32'd3);
            check("mem_we", mem_we, st);
            check("mem_wstrb", mem_wstrb, strb);
            check("early_wb", wb_valid, 0);
            if (st && n == 1) check("wdata_b", mem_wdata, wdata[7:0] * 32'h01010101);
            if (st && n == 2) check("wdata_h", mem_wdata, wdata[15:0] * 32'h00010001);
            if (st && n == 4) check("wdata_w", mem_wdata, wdata);
            for (int i = 0; i < rdy_dly; i++) begin
                @(negedge clk);
                check("req_hold", mem_req_valid, 1);
                check("addr_hold", mem_addr, addr & ~32'd3);
                check("strb_hold", mem_wstrb, strb);
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = $urandom_range(0, 1);
            check("one_hs", mem_req_valid, 0);
            check("wait_busy", busy, 1);
            if (tmo) begin
                for (int i = 0; i < TO; i++) begin
                    check("tmo_wait", wb_valid, 0);
                    check("tmo_noreq", mem_req_valid, 0);
                    @(negedge clk);
                end
                mem_req_ready = 1'b0;
                done_check(rd, 0, 3, st);
            end else begin
                for (int i = 0; i < rsp_dly; i++) begin
                    check("rsp_wait", wb_valid, 0);
                    @(negedge clk);
                end
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b1;
                mem_rdata     = rdata;
                mem_rsp_err   = err;
                @(negedge clk);
                mem_rsp_valid = 1'b0;
                mem_rsp_err   = 1'b0;
                mem_rdata     = $urandom;
                done_check(rd, (err || st) ? 0 : exp_load(f3, addr, rdata),
                           err ? 2 : 0, st);
            end
        end
        @(negedge clk);
        check("done_1cyc", wb_valid, 0);
        check("back_idle", busy, 0);
    endtask

    initial begin
        reset         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        req_is_store  = 1'b0;
        req_funct3    = '0;
        req_rd        = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        mem_rsp_err   = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_memv", mem_req_valid, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        txn(0, 3'd0, 32'h103, 32'h0, 5'd7, 32'h80FF_FF00, 0, 0, 0, 0);
        txn(1, 3'd1, 32'h202, 32'h1234_ABCD, 5'd3, 32'h0, 0, 0, 0, 0);
        txn(0, 3'd2, 32'h5, 32'h0, 5'd9, 32'h0, 0, 0, 0, 0);
        txn(0, 3'd2, 32'h300, 32'h0, 5'd4, 32'hCAFE_F00D, 3, 1, 0, 0);
        txn(0, 3'd2, 32'h400, 32'h0, 5'd6, 32'h0, 0, 0, 0, 1);
        txn(1, 3'd2, 32'h404, 32'h55AA_1234, 5'd6, 32'h0, 1, 0, 1, 0);
        txn(0, 3'd4, 32'h501, 32'h0, 5'd0, 32'h0000_9900, 0, TO - 1, 0, 0);
        txn(0, 3'd5, 32'h602, 32'h0, 5'd1, 32'h8001_0000, 0, 2, 0, 0);

        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'd2;
        req_addr     = 32'h40;
        req_rd       = 5'd5;
        @(negedge clk);
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("async_busy", busy, 0);
        @(negedge clk);
        check("rst_wbv2", wb_valid, 0);
        check("rst_wbwe", wb_we, 0);
        check("rst_wbd", wb_data, 0);
        check("rst_wbrd", wb_rd, 0);
        check("rst_exc", {exc_valid, exc_cause}, 0);
        check("rst_memv2", mem_req_valid, 0);
        check("rst_addr2", mem_addr, 0);
        reset         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1111_2222;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("late_rsp", wb_valid, 0);
        check("late_busy", busy, 0);
        @(negedge clk);
        check("late_rsp2", wb_valid, 0);

        for (int k = 0; k < 80; k++) begin
            bit          st, err, tmo;
            logic [2:0]  f3;
            logic [31:0] addr;
            logic [4:0]  rd;
            st   = $urandom_range(0, 1);
            f3   = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr = addr & ~(nbytes(f3) - 1);
            rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            err  = ($urandom_range(0, 7) == 0);
            tmo  = ($urandom_range(0, 7) == 0);
            txn(st, f3, addr, $urandom, rd, $urandom,
                $urandom_range(0, 2), $urandom_range(0, TO - 1), err, tmo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
